// File: rtl/pcs_tx_oset_gen.sv
// 1000BASE-X PCS transmit ordered-set / code-group generator (GMII -> unencoded code-groups).
// Optional /C/ configuration ordered sets are compiled in with `define PCS_TX_CONFIG_EN.
module pcs_tx_oset_gen #(
    parameter int unsigned IPG_MIN_OSETS = 1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             GTX_CLK,
    input  logic             mr_main_reset,
    input  logic [1:0]       xmit,
    input  logic [7:0]       TXD,
    input  logic             TX_EN,
    input  logic             TX_ER,
    input  logic             tx_disparity_pos,
`ifdef PCS_TX_CONFIG_EN
    input  logic [15:0]      tx_config_reg,
`endif
    output logic [7:0]       tx_o_data,
    output logic             tx_o_k,
    output logic             tx_even,
    output logic             TX_OSET_indicate,
    output logic             transmitting,
    output logic             frame_defer_err,
    output logic [CNT_W-1:0] tx_frame_cnt,
    output logic [CNT_W-1:0] tx_err_cnt
);

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] D5_6  = 8'hC5;
    localparam logic [7:0] D16_2 = 8'h50;
    localparam logic [7:0] K_S   = 8'hFB;
    localparam logic [7:0] K_T   = 8'hFD;
    localparam logic [7:0] K_R   = 8'hF7;
    localparam logic [7:0] K_V   = 8'hFE;
    localparam logic [3:0] IpgMin = 4'(IPG_MIN_OSETS);

    typedef enum logic [2:0] {
        StIdleEven,
        StIdleOdd,
        StPacket,
        StEpdT,
        StEpdR,
        StEpdR2
`ifdef PCS_TX_CONFIG_EN
        , StCfg
`endif
    } state_e;

    state_e           r_state, w_state_nxt;
    logic [7:0]       r_data, w_data;
    logic             r_k, w_k;
    logic             r_even;
    logic             r_oset, w_oset;
    logic             r_trans, w_trans;
    logic             r_defer, w_defer;
    logic             r_defer_seen, w_defer_seen_nxt;
    logic             r_disp, w_disp_nxt;
    logic [3:0]       r_ipg, w_ipg_nxt, w_ipg_inc;
    logic [CNT_W-1:0] r_frame_cnt, r_err_cnt;
    logic             w_frame_inc, w_err_inc;
    logic             w_data_mode, w_even_slot;
`ifdef PCS_TX_CONFIG_EN
    logic [15:0]      r_cfg, w_cfg_nxt;
    logic [1:0]       r_cfg_pos, w_cfg_pos_nxt;
    logic             r_c2, w_c2_nxt;
`endif

    assign w_data_mode = (xmit == 2'b10);
    // The code-group being computed lands in an even slot when tx_even is currently low.
    assign w_even_slot = ~r_even;
    assign w_ipg_inc   = (r_ipg == 4'd15) ? r_ipg : r_ipg + 4'd1;

    always_comb begin
        w_state_nxt      = r_state;
        w_data           = K28_5;
        w_k              = 1'b1;
        w_oset           = 1'b0;
        w_trans          = 1'b0;
        w_defer          = 1'b0;
        w_defer_seen_nxt = r_defer_seen & TX_EN;
        w_disp_nxt       = r_disp;
        w_ipg_nxt        = r_ipg;
        w_frame_inc      = 1'b0;
        w_err_inc        = 1'b0;
`ifdef PCS_TX_CONFIG_EN
        w_cfg_nxt        = r_cfg;
        w_cfg_pos_nxt    = r_cfg_pos;
        w_c2_nxt         = r_c2;
`endif
        case (r_state)
            StIdleEven: begin
                if (w_data_mode && TX_EN && (r_ipg >= IpgMin)) begin
                    w_data           = K_S;
                    w_oset           = 1'b1;
                    w_trans          = 1'b1;
                    w_defer_seen_nxt = 1'b0;
                    w_state_nxt      = StPacket;
`ifdef PCS_TX_CONFIG_EN
                end else if (xmit == 2'b01) begin
                    w_cfg_nxt     = tx_config_reg;
                    w_cfg_pos_nxt = 2'd1;
                    w_state_nxt   = StCfg;
`endif
                end else begin
                    w_disp_nxt  = tx_disparity_pos;
                    w_state_nxt = StIdleOdd;
                    if (w_data_mode && TX_EN && !r_defer_seen) begin
                        w_defer          = 1'b1;
                        w_defer_seen_nxt = 1'b1;
                    end
                end
            end
            StIdleOdd: begin
                w_data      = r_disp ? D5_6 : D16_2;
                w_k         = 1'b0;
                w_oset      = 1'b1;
                w_ipg_nxt   = w_ipg_inc;
                w_state_nxt = StIdleEven;
                // Blocked only if the coming even slot still cannot carry /S/.
                if (w_data_mode && TX_EN && (w_ipg_inc < IpgMin) && !r_defer_seen) begin
                    w_defer          = 1'b1;
                    w_defer_seen_nxt = 1'b1;
                end
            end
            StPacket: begin
                w_oset    = 1'b1;
                w_trans   = 1'b1;
                w_ipg_nxt = 4'd0;
                if (!w_data_mode) begin
                    w_data      = K_V;
                    w_err_inc   = 1'b1;
                    w_state_nxt = StEpdT;
                end else if (!TX_EN) begin
                    w_data      = K_T;
                    w_frame_inc = 1'b1;
                    w_state_nxt = StEpdR;
                end else if (TX_ER) begin
                    w_data    = K_V;
                    w_err_inc = 1'b1;
                end else begin
                    w_data = TXD;
                    w_k    = 1'b0;
                end
            end
            StEpdT: begin
                w_data      = K_T;
                w_oset      = 1'b1;
                w_trans     = 1'b1;
                w_frame_inc = 1'b1;
                w_ipg_nxt   = 4'd0;
                w_state_nxt = StEpdR;
            end
            StEpdR: begin
                w_data      = K_R;
                w_oset      = 1'b1;
                w_ipg_nxt   = 4'd0;
                w_state_nxt = w_even_slot ? StEpdR2 : StIdleEven;
            end
            StEpdR2: begin
                w_data      = K_R;
                w_oset      = 1'b1;
                w_ipg_nxt   = 4'd0;
                w_state_nxt = StIdleEven;
            end
`ifdef PCS_TX_CONFIG_EN
            StCfg: begin
                w_k           = 1'b0;
                w_cfg_pos_nxt = r_cfg_pos + 2'd1;
                case (r_cfg_pos)
                    2'd1:    w_data = r_c2 ? 8'h42 : 8'hB5;
                    2'd2:    w_data = r_cfg[7:0];
                    default: begin
                        w_data      = r_cfg[15:8];
                        w_oset      = 1'b1;
                        w_c2_nxt    = ~r_c2;
                        w_state_nxt = StIdleEven;
                    end
                endcase
            end
`endif
            default: w_state_nxt = StIdleEven;
        endcase
    end

    always_ff @(posedge GTX_CLK) begin
        if (mr_main_reset) begin
            r_state      <= StIdleOdd;
            r_data       <= K28_5;
            r_k          <= 1'b1;
            r_even       <= 1'b1;
            r_oset       <= 1'b0;
            r_trans      <= 1'b0;
            r_defer      <= 1'b0;
            r_defer_seen <= 1'b0;
            r_disp       <= 1'b0;
            r_ipg        <= IpgMin;
            r_frame_cnt  <= '0;
            r_err_cnt    <= '0;
`ifdef PCS_TX_CONFIG_EN
            r_cfg        <= '0;
            r_cfg_pos    <= 2'd1;
            r_c2         <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_data       <= w_data;
            r_k          <= w_k;
            r_even       <= ~r_even;
            r_oset       <= w_oset;
            r_trans      <= w_trans;
            r_defer      <= w_defer;
            r_defer_seen <= w_defer_seen_nxt;
            r_disp       <= w_disp_nxt;
            r_ipg        <= w_ipg_nxt;
            if (w_frame_inc && (r_frame_cnt != '1)) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            if (w_err_inc && (r_err_cnt != '1))     r_err_cnt   <= r_err_cnt + CNT_W'(1);
`ifdef PCS_TX_CONFIG_EN
            r_cfg        <= w_cfg_nxt;
            r_cfg_pos    <= w_cfg_pos_nxt;
            r_c2         <= w_c2_nxt;
`endif
        end
    end

    assign tx_o_data        = r_data;
    assign tx_o_k           = r_k;
    assign tx_even          = r_even;
    assign TX_OSET_indicate = r_oset;
    assign transmitting     = r_trans;
    assign frame_defer_err  = r_defer;
    assign tx_frame_cnt     = r_frame_cnt;
    assign tx_err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_pcs_tx_oset_gen.sv
// Directed bench for pcs_tx_oset_gen (IPG_MIN_OSETS = 3, CNT_W = 3 to reach counter saturation).
module tb_pcs_tx_oset_gen;

    localparam int unsigned CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       xmit;
    logic [7:0]       txd;
    logic             tx_en, tx_er, disp;
    logic [15:0]      cfg_reg;
    logic [7:0]       o_data;
    logic             o_k, o_even, o_oset, o_trans, o_defer;
    logic [CNT_W-1:0] frame_cnt, err_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pcs_tx_oset_gen #(
        .IPG_MIN_OSETS(3),
        .CNT_W        (CNT_W)
    ) dut (
        .GTX_CLK         (clk),
        .mr_main_reset   (rst),
        .xmit            (xmit),
        .TXD             (txd),
        .TX_EN           (tx_en),
        .TX_ER           (tx_er),
        .tx_disparity_pos(disp),
`ifdef PCS_TX_CONFIG_EN
        .tx_config_reg   (cfg_reg),
`endif
        .tx_o_data       (o_data),
        .tx_o_k          (o_k),
        .tx_even         (o_even),
        .TX_OSET_indicate(o_oset),
        .transmitting    (o_trans),
        .frame_defer_err (o_defer),
        .tx_frame_cnt    (frame_cnt),
        .tx_err_cnt      (err_cnt)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one GMII cycle, then check the {k, octet} registered at that edge.
    task automatic send(input string tag, input logic en, input logic er, input logic [7:0] d,
                        input logic [8:0] exp);
        tx_en = en;
        tx_er = er;
        txd   = d;
        cyc();
        chk(tag, {7'd0, o_k, o_data}, {7'd0, exp});
    endtask

    logic [8:0] cfg_exp [8];

    initial begin
        rst = 1'b1; xmit = 2'b00; txd = 8'h00; tx_en = 1'b0; tx_er = 1'b0; disp = 1'b0;
        cfg_reg = 16'h01A0;
        repeat (3) cyc();
        chk("rst_cg", {7'd0, o_k, o_data}, 16'h01BC);
        chk("rst_even", {15'd0, o_even}, 16'd1);
        chk("rst_oset", {15'd0, o_oset}, 16'd0);
        chk("rst_trans", {15'd0, o_trans}, 16'd0);
        chk("rst_defer", {15'd0, o_defer}, 16'd0);
        chk("rst_fcnt", {13'd0, frame_cnt}, 16'd0);
        chk("rst_ecnt", {13'd0, err_cnt}, 16'd0);

        // Idle stream: first cycle after reset is the odd half.
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (i % 2 == 0) begin
                chk("idle_odd_cg", {7'd0, o_k, o_data}, 16'h0050);
                chk("idle_odd_even", {15'd0, o_even}, 16'd0);
                chk("idle_odd_oset", {15'd0, o_oset}, 16'd1);
            end else begin
                chk("idle_even_cg", {7'd0, o_k, o_data}, 16'h01BC);
                chk("idle_even_even", {15'd0, o_even}, 16'd1);
                chk("idle_even_oset", {15'd0, o_oset}, 16'd0);
            end
        end

        // Positive disparity seen at the K28.5 slot selects /I1/.
        disp = 1'b1;
        send("disp_odd_prev", 0, 0, 8'h00, 9'h050);
        send("disp_even", 0, 0, 8'h00, 9'h1BC);
        disp = 1'b0;
        send("disp_i1", 0, 0, 8'h00, 9'h0C5);

        // Frame 1: TX_EN rises on an even slot; /T/ odd, /R/ even -> two /R/.
        xmit = 2'b10;
        send("f1_s", 1, 0, 8'h55, 9'h1FB);
        chk("f1_s_trans", {15'd0, o_trans}, 16'd1);
        chk("f1_s_even", {15'd0, o_even}, 16'd1);
        send("f1_d1", 1, 0, 8'h55, 9'h055);
        send("f1_d2", 1, 0, 8'hD5, 9'h0D5);
        send("f1_d3", 1, 0, 8'h01, 9'h001);
        send("f1_d4", 1, 0, 8'h9A, 9'h09A);
        send("f1_d5", 1, 0, 8'hB5, 9'h0B5);
        send("f1_d6", 1, 0, 8'h42, 9'h042);
        send("f1_t", 0, 0, 8'h00, 9'h1FD);
        chk("f1_t_trans", {15'd0, o_trans}, 16'd1);
        chk("f1_fcnt", {13'd0, frame_cnt}, 16'd1);
        send("f1_r1", 0, 0, 8'h00, 9'h1F7);
        chk("f1_r1_trans", {15'd0, o_trans}, 16'd0);
        chk("f1_r1_even", {15'd0, o_even}, 16'd1);
        send("f1_r2", 0, 0, 8'h00, 9'h1F7);
        send("f1_idle_k", 0, 0, 8'h00, 9'h1BC);
        chk("f1_idle_even", {15'd0, o_even}, 16'd1);
        send("f1_idle_d", 0, 0, 8'h00, 9'h050);

        // Frame 2: one idle set after EPD; start blocked until three sets complete.
        send("f2_blk0", 1, 0, 8'h11, 9'h1BC);
        chk("f2_defer_pulse", {15'd0, o_defer}, 16'd1);
        send("f2_blk1", 1, 0, 8'h22, 9'h050);
        chk("f2_defer_once", {15'd0, o_defer}, 16'd0);
        send("f2_blk2", 1, 0, 8'h33, 9'h1BC);
        chk("f2_defer_once2", {15'd0, o_defer}, 16'd0);
        send("f2_blk3", 1, 0, 8'h44, 9'h050);
        send("f2_s", 1, 0, 8'h55, 9'h1FB);
        send("f2_d1", 1, 0, 8'h66, 9'h066);
        send("f2_d2", 1, 0, 8'h77, 9'h077);
        send("f2_t", 0, 0, 8'h00, 9'h1FD);
        chk("f2_fcnt", {13'd0, frame_cnt}, 16'd2);
        send("f2_r1", 0, 0, 8'h00, 9'h1F7);
        send("f2_r2", 0, 0, 8'h00, 9'h1F7);
        send("f2_idle", 0, 0, 8'h00, 9'h1BC);

        // Frame 3: TX_EN rises on an odd slot (first octet dropped), TX_ER on one octet.
        send("f3_gap0", 0, 0, 8'h00, 9'h050);
        send("f3_gap1", 0, 0, 8'h00, 9'h1BC);
        send("f3_gap2", 0, 0, 8'h00, 9'h050);
        send("f3_gap3", 0, 0, 8'h00, 9'h1BC);
        send("f3_drop", 1, 0, 8'h55, 9'h050);
        chk("f3_no_defer", {15'd0, o_defer}, 16'd0);
        send("f3_s", 1, 0, 8'h55, 9'h1FB);
        send("f3_d1", 1, 0, 8'hD5, 9'h0D5);
        send("f3_v", 1, 1, 8'h01, 9'h1FE);
        chk("f3_ecnt", {13'd0, err_cnt}, 16'd1);
        send("f3_d3", 1, 0, 8'h9A, 9'h09A);
        send("f3_d4", 1, 0, 8'hB5, 9'h0B5);
        send("f3_d5", 1, 0, 8'h42, 9'h042);
        send("f3_t", 0, 0, 8'h00, 9'h1FD);
        chk("f3_t_even", {15'd0, o_even}, 16'd1);
        send("f3_r1", 0, 0, 8'h00, 9'h1F7);
        send("f3_idle", 0, 0, 8'h00, 9'h1BC);
        chk("f3_fcnt", {13'd0, frame_cnt}, 16'd3);

        // Frame 4: error counter saturates, then xmit leaves DATA mid-frame.
        send("f4_gap0", 0, 0, 8'h00, 9'h050);
        send("f4_gap1", 0, 0, 8'h00, 9'h1BC);
        send("f4_gap2", 0, 0, 8'h00, 9'h050);
        send("f4_gap3", 0, 0, 8'h00, 9'h1BC);
        send("f4_gap4", 0, 0, 8'h00, 9'h050);
        send("f4_s", 1, 0, 8'h00, 9'h1FB);
        for (int i = 0; i < 8; i++) send("f4_v", 1, 1, 8'(i), 9'h1FE);
        chk("f4_ecnt_sat", {13'd0, err_cnt}, 16'd7);
        xmit = 2'b00;
        send("f4_leave_v", 1, 0, 8'h12, 9'h1FE);
        chk("f4_leave_trans", {15'd0, o_trans}, 16'd1);
        chk("f4_ecnt_hold", {13'd0, err_cnt}, 16'd7);
        send("f4_t", 0, 0, 8'h00, 9'h1FD);
        chk("f4_t_trans", {15'd0, o_trans}, 16'd1);
        chk("f4_fcnt", {13'd0, frame_cnt}, 16'd4);
        send("f4_r1", 0, 0, 8'h00, 9'h1F7);
        send("f4_idle", 0, 0, 8'h00, 9'h1BC);

        // Reset mid-packet aborts at once.
        xmit = 2'b10;
        send("f5_gap0", 0, 0, 8'h00, 9'h050);
        send("f5_gap1", 0, 0, 8'h00, 9'h1BC);
        send("f5_gap2", 0, 0, 8'h00, 9'h050);
        send("f5_gap3", 0, 0, 8'h00, 9'h1BC);
        send("f5_gap4", 0, 0, 8'h00, 9'h050);
        send("f5_s", 1, 0, 8'hAA, 9'h1FB);
        send("f5_d1", 1, 0, 8'hBB, 9'h0BB);
        rst = 1'b1;
        send("f5_rst_cg", 1, 0, 8'hCC, 9'h1BC);
        chk("f5_rst_trans", {15'd0, o_trans}, 16'd0);
        chk("f5_rst_fcnt", {13'd0, frame_cnt}, 16'd0);
        chk("f5_rst_ecnt", {13'd0, err_cnt}, 16'd0);
        chk("f5_rst_even", {15'd0, o_even}, 16'd1);

        // xmit = CONFIGURATION: /C1/ /C2/ with the macro, plain idles without it.
        rst  = 1'b0;
        xmit = 2'b01;
        send("cfg_first_odd", 0, 0, 8'h00, 9'h050);
`ifdef PCS_TX_CONFIG_EN
        cfg_exp = '{9'h1BC, 9'h0B5, 9'h0A0, 9'h001, 9'h1BC, 9'h042, 9'h0A0, 9'h001};
`else
        cfg_exp = '{9'h1BC, 9'h050, 9'h1BC, 9'h050, 9'h1BC, 9'h050, 9'h1BC, 9'h050};
`endif
        for (int i = 0; i < 8; i++) begin
            send("cfg_cg", 0, 0, 8'h00, cfg_exp[i]);
            if (i == 3) chk("cfg_oset", {15'd0, o_oset}, 16'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pcs_tx_oset_gen.md
# pcs_tx_oset_gen

Parametrised 1000BASE-X PCS transmit ordered-set generator that merges the ordered-set and code-group sub-machines into one registered block. It converts GMII TXD/TX_EN/TX_ER into an unencoded code-group stream (octet plus K flag) for the downstream 8b/10b encoder. It adds even-alignment enforcement, disparity-aware idle selection, minimum inter-frame idle enforcement and saturating frame/error counters. The optional /C/ configuration mode is compiled in by macro.

## Interface
- IPG_MIN_OSETS, default 1: minimum completed idle ordered sets after end-of-packet before /S/ is allowed (range 1..15).
- CNT_W, default 16: width of the saturating counters.

- GTX_CLK  in  1  transmit clock; all logic on the rising edge.
- mr_main_reset  in  1  reset; one clock, synchronous, active-high.
- xmit  in  2  mode select: 00 IDLE, 01 CONFIGURATION, 10 DATA; 11 is treated as IDLE.
- TXD  in  8  GMII transmit octet.
- TX_EN  in  1  GMII transmit enable.
- TX_ER  in  1  GMII transmit error.
- tx_disparity_pos  in  1  encoder running disparity; 1 = positive.
- tx_config_reg  in  16  autoneg config word; present only with PCS_TX_CONFIG_EN.
- tx_o_data  out  8  code-group octet.
- tx_o_k  out  1  code-group is a K character.
- tx_even  out  1  current code-group occupies an even slot.
- TX_OSET_indicate  out  1  last code-group of an ordered set.
- transmitting  out  1  frame in progress.
- frame_defer_err  out  1  one-cycle pulse; frame start blocked by IPG.
- tx_frame_cnt  out  CNT_W  frames ended with /T/; saturating.
- tx_err_cnt  out  CNT_W  /V/ code-groups emitted; saturating.

## Operation
- Code points:
  - K28.5 = BC(k), D5.6 = C5, D16.2 = 50.
  - /S/ = FB(k), /T/ = FD(k), /R/ = F7(k), /V/ = FE(k).
  - D21.5 = B5, D2.2 = 42.
- States: IDLE_EVEN, IDLE_ODD, PACKET, EPD_T, EPD_R, EPD_R2, CFG (macro only).
- Idle: two code-groups.
  - Even slot: K28.5.
  - Odd slot: D5.6 (/I1/) if tx_disparity_pos = 1 at the even slot, else D16.2 (/I2/).
- Frame start:
  - Decided only at an even slot, in IDLE_EVEN.
  - Requires xmit = DATA, TX_EN = 1 and the IPG counter ≥ IPG_MIN_OSETS.
  - Emits /S/ in place of the current TXD octet, then enters PACKET.
  - TX_EN rising during an odd slot: the idle completes, /S/ goes on the next even slot, and the first octet is dropped.
- PACKET, per cycle:
  - TX_EN = 1, TX_ER = 0: TXD (k = 0).
  - TX_EN = 1, TX_ER = 1: /V/, tx_err_cnt +1.
  - TX_EN = 0: /T/, then EPD_R.
- End of packet:
  - /T/ increments tx_frame_cnt.
  - EPD_R emits /R/.
  - If that /R/ sits on an even slot, EPD_R2 emits a second /R/ so the next idle starts even.
  - Afterwards the IPG counter clears to 0.
- IPG counter: +1 per completed idle ordered set; saturates at 15.
- IPG-blocked start:
  - While the counter < IPG_MIN_OSETS, TX_EN = 1 octets are dropped.
  - frame_defer_err pulses on the first blocked TX_EN cycle of that frame.
  - /S/ goes at the first allowed even slot.
- TX_EN toggling during EPD or IDLE_ODD is ignored until an even boundary.
- xmit leaving DATA while in PACKET: emit /V/ (tx_err_cnt +1), then /T/ and EPD normally, then the new mode.
- TX_ER with TX_EN = 0 is ignored; carrier extension is not supported.
- TX_OSET_indicate = 1 on the odd half of each idle, on every PACKET/EPD code-group, and on the 4th code-group of a /C/.
- transmitting = 1 from the /S/ cycle through the /T/ cycle inclusive.

## Timing
- All outputs are registered.
- Latency: TXD octet present before edge n appears on tx_o_data after edge n.
- tx_even toggles every cycle outside reset.
- Reset values (held while reset is asserted):
  - tx_o_data = BC, tx_o_k = 1, tx_even = 1.
  - TX_OSET_indicate = 0, transmitting = 0, frame_defer_err = 0.
  - Both counters = 0.
  - IPG counter = IPG_MIN_OSETS.
  - State = IDLE_ODD.
- First cycle after reset: the odd half of an idle.
- Reset mid-packet aborts immediately. No /T/ is sent and no count is taken.
- Counters hold at all-ones.

## Configuration
- PCS_TX_CONFIG_EN defined:
  - xmit = 01 enters CFG at an even boundary outside PACKET.
  - CFG alternates /C1/ (BC, B5, cfg[7:0], cfg[15:8]) and /C2/ (BC, 42, cfg[7:0], cfg[15:8]).
  - tx_config_reg is sampled at each K28.5 slot.
  - CFG exits only after a complete /C/.
- PCS_TX_CONFIG_EN undefined:
  - The tx_config_reg port is absent.
  - xmit = 01 behaves as IDLE.

## Test plan
- Reset 3 cycles, then xmit = IDLE for 8 cycles, tx_disparity_pos = 0 → BC,50 alternating; tx_even 1,0,…; TX_OSET_indicate on the 50s.
- xmit = DATA, TX_EN rises on an even slot with TXD 55,55,D5,01,9A,B5,42 → FB,55,D5,01,9A,B5,42,FD,F7(,F7 if that F7 is even); tx_frame_cnt = 1.
- Same frame with TX_EN rising on an odd slot → first 55 dropped, FB one cycle later; /R/ count chosen so the next K28.5 is even.
- TX_ER = 1 on the 3rd data octet → FE in that slot; tx_err_cnt = 1; frame still ends FD,F7.
- IPG_MIN_OSETS = 3, back-to-back frame with one idle between → frame_defer_err pulse; FB only after 3 idle sets; leading octets dropped.
- PCS_TX_CONFIG_EN, xmit = 01, tx_config_reg = 01A0 → BC,B5,A0,01,BC,42,A0,01 repeating; with the macro undefined → idles only.
